// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops words from a show-ahead FIFO and shifts them out
// MSB-first on a 1-bit link with frame/start markers, an optional even-parity
// bit and a fixed idle gap between frames. The link can stall via ser_rdy_i.
module fifo_word_serializer #(
  parameter int DWID   = 16,
  parameter int PAR_EN = 1,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            empty_i,
  input  logic [DWID-1:0] rdata_i,
  output logic            rd_o,
  output logic            ser_o,
  output logic            frame_o,
  output logic            sof_o,
  input  logic            ser_rdy_i,
  output logic            busy_o,
  output logic [15:0]     word_cnt_o
);

  localparam int CW = $clog2(DWID);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PAR    = 2'd2;
  localparam logic [1:0] GAP_ST = 2'd3;

  // Where a finished frame goes: into the idle gap, or straight back to IDLE.
  localparam logic [1:0]    AFTER    = (GAP > 0) ? GAP_ST : IDLE;
  localparam logic [CW-1:0] LAST_BIT = CW'(DWID - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [1:0]      state_q, state_d;
  logic [DWID-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            par_q, par_d;
  logic [15:0]     word_cnt_q, word_cnt_d;

  // Pop strobe: only from IDLE, never on an empty FIFO, never during reset.
  assign rd_o = (state_q == IDLE) && !empty_i && !rst;

  // Link-side outputs are decoded from the current state.
  always_comb begin
    ser_o   = 1'b0;
    frame_o = 1'b0;
    sof_o   = 1'b0;
    case (state_q)
      SHIFT: begin
        ser_o   = shreg_q[DWID-1];
        frame_o = 1'b1;
        sof_o   = (bit_cnt_q == '0);
      end
      PAR: begin
        ser_o   = par_q;
        frame_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign word_cnt_o = word_cnt_q;

  // Next-state logic for the frame sequencer and its datapath.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    par_d      = par_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_o) begin
          shreg_d   = rdata_i;
          bit_cnt_d = '0;
          par_d     = ^rdata_i;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_rdy_i) begin
          shreg_d   = {shreg_q[DWID-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            if (PAR_EN != 0) begin
              state_d = PAR;
            end else begin
              // Last data bit accepted closes the frame when there is no parity.
              word_cnt_d = word_cnt_q + 16'd1;
              gap_cnt_d  = 4'd0;
              state_d    = AFTER;
            end
          end
        end
      end
      PAR: begin
        if (ser_rdy_i) begin
          word_cnt_d = word_cnt_q + 16'd1;
          gap_cnt_d  = 4'd0;
          state_d    = AFTER;
        end
      end
      GAP_ST: begin
        // Gap is timed in clock cycles; the link handshake plays no part here.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= 4'd0;
      par_q      <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      par_q      <= par_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer of the team's synchronous FIFO. It pops one DWID-bit word at a time from the FIFO's show-ahead read port, where rdata is valid combinationally whenever the FIFO is not empty. It shifts the word out MSB-first on a 1-bit serial link with frame and start markers, appends an optional even-parity bit, and inserts a programmable idle gap between frames. The serial link can stall the shifting through ser_rdy_i.

Parameters:
DWID, 16, word width; must match the FIFO data width; DWID >= 2.
PAR_EN, 1, 1 = append one even-parity bit after the data bits; 0 = no parity bit.
GAP, 2, idle cycles forced after each frame before the next pop; range 0..15.

Ports:
clk  input  1  rising-edge clock shared with the FIFO.
rst  input  1  synchronous, active-high reset.
empty_i  input  1  FIFO empty flag.
rdata_i  input  DWID  FIFO head word; valid whenever empty_i=0.
rd_o  output  1  FIFO pop strobe; at most one cycle per frame.
ser_o  output  1  serial data bit.
frame_o  output  1  high while a data or parity bit is presented on ser_o.
sof_o  output  1  high while the first data bit of a frame is presented.
ser_rdy_i  input  1  link accepts the presented bit on this edge.
busy_o  output  1  state != IDLE.
word_cnt_o  output  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset: synchronous, active-high, and dominates all other inputs.
  - state=IDLE; shreg=0; bit_cnt=0; gap_cnt=0; word_cnt_o=0.
  - ser_o=0, frame_o=0, sof_o=0, busy_o=0.
  - rd_o is gated to 0 during any cycle in which rst=1.
- Reset mid-frame: the partial frame is abandoned and no further bits are emitted. The popped word is lost and word_cnt_o is not incremented.
- States: IDLE, SHIFT, PAR, GAP.
- IDLE:
  - rd_o = (state==IDLE) && !empty_i && !rst. It is combinational.
  - On an edge with rd_o=1: shreg<=rdata_i, bit_cnt<=0, parity accumulator<=^rdata_i, next state SHIFT.
  - Pop-to-first-bit latency is 1 cycle: rd_o at cycle N, first bit on ser_o at N+1.
- SHIFT:
  - ser_o=shreg[DWID-1], frame_o=1, sof_o=(bit_cnt==0).
  - On an edge with ser_rdy_i=1: shreg<=shreg<<1 and bit_cnt++.
  - When bit_cnt==DWID-1 is accepted: go to PAR if PAR_EN, else to GAP if GAP>0, else to IDLE.
  - ser_rdy_i=0 holds ser_o, sof_o and all state.
- PAR:
  - ser_o = even-parity bit (XOR of the data word), frame_o=1, sof_o=0.
  - On an edge with ser_rdy_i=1: go to GAP if GAP>0, else to IDLE.
- GAP:
  - ser_o=0, frame_o=0.
  - Counts GAP cycles unconditionally; ser_rdy_i is ignored.
  - Then goes to IDLE.
- Outside SHIFT and PAR: ser_o=0, frame_o=0, sof_o=0.
- Frame completion: word_cnt_o increments on the edge that accepts the final bit of a frame (the parity bit if PAR_EN, else data bit DWID-1).
- Throughput:
  - A frame occupies DWID+PAR_EN accepted bits, plus GAP cycles, plus 1 IDLE cycle.
  - Back-to-back minimum period with ser_rdy_i=1 is DWID+PAR_EN+GAP+1 cycles.
- FIFO empty: while empty_i=1 the block stays in IDLE with rd_o=0.
  - It never pops an empty FIFO.
  - empty_i is sampled only in IDLE. Changes during a frame are ignored.
- Word capture: the word is captured from rdata_i in the same cycle as rd_o. The FIFO may then advance freely.
- Widths: bit_cnt is $clog2(DWID) bits; gap_cnt is 4 bits. All arithmetic is unsigned, with no overflow except the word_cnt_o wrap.

Test Plan:
- Reset, then empty_i=1 for 20 cycles -> rd_o=0, busy_o=0, ser_o=0, word_cnt_o=0 throughout.
- Defaults, single word 0xA5C3, ser_rdy_i=1:
  - rd_o pulses 1 cycle; sof_o and frame_o rise the next cycle.
  - ser_o = 1010010111000011 followed by parity bit 0 (popcount 8).
  - frame_o high for 17 cycles, then 2 GAP cycles; word_cnt_o=1.
- Two queued words 0x0001 then 0xFFFE, ser_rdy_i=1:
  - Parity bits are 1 and 1.
  - Second rd_o occurs exactly 20 cycles after the first.
  - word_cnt_o=2.
- Word 0x8000 with ser_rdy_i toggling 1,0,1,0:
  - Each bit is held while ser_rdy_i=0.
  - sof_o stays high until the first bit is accepted.
  - Frame completes after 17 accepts.
- Assert rst for 1 cycle after the 5th data bit of 0x1234:
  - Next cycle: state IDLE, ser_o=0, frame_o=0, word_cnt_o unchanged.
  - A subsequent word 0x00FF serializes correctly.
- PAR_EN=0, GAP=0, 3 queued words:
  - Frame period is 17 cycles (16 bits + 1 IDLE), with no parity bit.
  - Preload word_cnt_o path to 0xFFFE -> reads 0x0001 after the 3 frames.
